// File: rtl/combo_lock_pkg.sv
// combo_lock_pkg
// Types and constants shared by the combination-lock controller and the
// seven-segment decoder stage that consumes its display code.
//   lock_state_e   : controller state encoding
//   DISP_*         : 4-bit display codes ("L", "U", "H")
//   state_to_disp  : maps a state onto its display code
package combo_lock_pkg;

    typedef enum logic [1:0] {
        ST_LOCKED   = 2'd0,
        ST_UNLOCKED = 2'd1,
        ST_LOCKOUT  = 2'd2
    } lock_state_e;

    localparam logic [3:0] DISP_LOCKED   = 4'h0;
    localparam logic [3:0] DISP_UNLOCKED = 4'h1;
    localparam logic [3:0] DISP_LOCKOUT  = 4'h2;

    function automatic logic [3:0] state_to_disp(input lock_state_e st);
        logic [3:0] disp;
        case (st)
            ST_UNLOCKED: disp = DISP_UNLOCKED;
            ST_LOCKOUT:  disp = DISP_LOCKOUT;
            default:     disp = DISP_LOCKED;
        endcase
        return disp;
    endfunction

endpackage

// File: rtl/rise_detect.sv
// rise_detect
// Single-cycle pulse on the rising edge of a debounced button level.
//   clk    : system clock
//   rst_n  : synchronous active-low reset
//   in     : debounced button level
//   pulse  : high for one cycle when in goes 0 -> 1
// The history register resets to 1, so a button already held when reset
// is released is not reported as a press.
module rise_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic in,
    output logic pulse
);

    logic prev_q;
    logic prev_d;

    assign prev_d = in;
    assign pulse  = in & ~prev_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_q <= 1'b1;
        end else begin
            prev_q <= prev_d;
        end
    end

endmodule

// File: rtl/combo_lock_fsm.sv
// combo_lock_fsm
// Combination-lock controller: collects CODE_LEN digits on enter presses,
// compares them with CODE, counts consecutive failures and imposes a timed
// lockout after MAX_FAIL failures.
//   clk       : system clock
//   rst_n     : synchronous active-low reset
//   digit_in  : debounced digit switches, sampled on an enter press
//   enter     : debounced enter button level
//   clear     : debounced clear button level
//   disp_val  : display code (locked / unlocked / lockout)
//   unlocked  : high only while unlocked
//   entry_idx : digits accepted in the current attempt
//   fail_cnt  : consecutive failed attempts, saturates at MAX_FAIL
//
// state       | meaning
// ------------+----------------------------------------------------------
// ST_LOCKED   | collecting digits; evaluates on the CODE_LEN-th press
// ST_UNLOCKED | correct code seen; any press or clear relocks
// ST_LOCKOUT  | too many failures; presses ignored until the timer expires
module combo_lock_fsm
    import combo_lock_pkg::*;
#(
    parameter int                    CODE_LEN       = 4,
    parameter logic [4*CODE_LEN-1:0] CODE           = 16'h1234,
    parameter int                    MAX_FAIL       = 3,
    parameter int                    LOCKOUT_CYCLES = 100_000_000
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [3:0]                      digit_in,
    input  logic                            enter,
    input  logic                            clear,
    output logic [3:0]                      disp_val,
    output logic                            unlocked,
    output logic [2:0]                      entry_idx,
    output logic [$clog2(MAX_FAIL+1)-1:0]   fail_cnt
);

    localparam int FW = $clog2(MAX_FAIL + 1);
    localparam int TW = $clog2(LOCKOUT_CYCLES + 1);

    localparam logic [2:0]    LAST_IDX   = 3'(CODE_LEN - 1);
    localparam logic [FW-1:0] FAIL_LAST  = FW'(MAX_FAIL - 1);
    localparam logic [FW-1:0] FAIL_SAT   = FW'(MAX_FAIL);
    localparam logic [TW-1:0] TIMER_LOAD = TW'(LOCKOUT_CYCLES - 1);

    logic enter_pulse;
    logic clr_pulse;

    rise_detect u_enter_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .in    (enter),
        .pulse (enter_pulse)
    );

    rise_detect u_clear_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .in    (clear),
        .pulse (clr_pulse)
    );

    lock_state_e   state_q,     state_d;
    logic [2:0]    entry_idx_q, entry_idx_d;
    logic          mismatch_q,  mismatch_d;
    logic [FW-1:0] fail_cnt_q,  fail_cnt_d;
    logic [TW-1:0] timer_q,     timer_d;
    logic [3:0]    disp_val_q,  disp_val_d;
    logic          unlocked_q,  unlocked_d;

    logic [3:0] exp_digit;
    logic       digit_bad;

    // Code digit expected at the current position; the first digit entered
    // is the most-significant nibble of CODE.
    always_comb begin
        exp_digit = CODE[4*CODE_LEN-1 -: 4];
        for (int i = 0; i < CODE_LEN; i++) begin
            if (entry_idx_q == 3'(i)) begin
                exp_digit = CODE[4*(CODE_LEN-1-i) +: 4];
            end
        end
    end

    assign digit_bad = (digit_in != exp_digit);

    always_comb begin
        state_d     = state_q;
        entry_idx_d = entry_idx_q;
        mismatch_d  = mismatch_q;
        fail_cnt_d  = fail_cnt_q;
        timer_d     = timer_q;

        case (state_q)
            ST_LOCKED: begin
                // Clear takes priority and swallows a coincident press.
                if (clr_pulse) begin
                    entry_idx_d = '0;
                    mismatch_d  = 1'b0;
                end else if (enter_pulse) begin
                    if (entry_idx_q == LAST_IDX) begin
                        entry_idx_d = '0;
                        mismatch_d  = 1'b0;
                        if (!(mismatch_q | digit_bad)) begin
                            state_d    = ST_UNLOCKED;
                            fail_cnt_d = '0;
                        end else if (fail_cnt_q == FAIL_LAST) begin
                            state_d    = ST_LOCKOUT;
                            timer_d    = TIMER_LOAD;
                            fail_cnt_d = FAIL_SAT;
                        end else begin
                            fail_cnt_d = fail_cnt_q + 1'b1;
                        end
                    end else begin
                        entry_idx_d = entry_idx_q + 3'd1;
                        mismatch_d  = mismatch_q | digit_bad;
                    end
                end
            end

            ST_UNLOCKED: begin
                if (enter_pulse || clr_pulse) begin
                    state_d     = ST_LOCKED;
                    entry_idx_d = '0;
                    mismatch_d  = 1'b0;
                end
            end

            ST_LOCKOUT: begin
                // Timer loads LOCKOUT_CYCLES-1 and exits the cycle after it
                // reads zero, giving exactly LOCKOUT_CYCLES lockout cycles.
                if (timer_q == '0) begin
                    state_d    = ST_LOCKED;
                    fail_cnt_d = '0;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end

            default: begin
                state_d     = ST_LOCKED;
                entry_idx_d = '0;
                mismatch_d  = 1'b0;
                fail_cnt_d  = '0;
                timer_d     = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they move with the state.
    always_comb begin
        disp_val_d = state_to_disp(state_d);
        unlocked_d = (state_d == ST_UNLOCKED);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_LOCKED;
            entry_idx_q <= '0;
            mismatch_q  <= 1'b0;
            fail_cnt_q  <= '0;
            timer_q     <= '0;
            disp_val_q  <= DISP_LOCKED;
            unlocked_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            entry_idx_q <= entry_idx_d;
            mismatch_q  <= mismatch_d;
            fail_cnt_q  <= fail_cnt_d;
            timer_q     <= timer_d;
            disp_val_q  <= disp_val_d;
            unlocked_q  <= unlocked_d;
        end
    end

    assign disp_val  = disp_val_q;
    assign unlocked  = unlocked_q;
    assign entry_idx = entry_idx_q;
    assign fail_cnt  = fail_cnt_q;

endmodule
